filter_coe_scheduler: RTL and testbench
=======================================

Name: filter_coe_scheduler

Overview:
- Owns the coefficient matrix used by the stream video convolution filter.
- Software writes a shadow bank through a simple register-style port, then requests a commit.
- The block copies shadow to active only on an accepted start-of-frame beat of the filter's input stream, so every frame is filtered with one consistent kernel.
- A timeout fallback commits when the stream is stalled or absent.

Parameters:
- FILTER_CORE_DIM, 5, kernel is FILTER_CORE_DIM x FILTER_CORE_DIM.
- COE_WIDTH, 16, signed coefficient width (Q1.(COE_WIDTH-1)).
- ADDR_W, 5, coefficient address width; must satisfy 2**ADDR_W >= FILTER_CORE_DIM**2.
- IDLE_TIMEOUT, 1024, cycles without an accepted beat while armed before a forced commit; 0 disables the fallback.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- cfg_waddr  in  ADDR_W  coefficient index k = row*FILTER_CORE_DIM + col.
- cfg_wdata  in  COE_WIDTH  signed coefficient value.
- cfg_we  in  1  shadow write strobe.
- cfg_commit  in  1  commit request pulse.
- cfg_busy  out  1  high in ARMED or DONE.
- cfg_err  out  1  one-cycle pulse on a rejected write.
- commit_done  out  1  one-cycle pulse in the cycle after the active bank updates.
- forced_commit  out  1  sticky; set by a timeout commit, cleared by the next SOF commit.
- mon_tvalid  in  1  filter input tvalid, monitor only.
- mon_tready  in  1  filter input tready, monitor only.
- mon_tuser  in  1  filter input tuser (SOF), monitor only.
- coe_flat  out  FILTER_CORE_DIM*FILTER_CORE_DIM*COE_WIDTH  active bank; coefficient k is at [k*COE_WIDTH +: COE_WIDTH].

Behaviour:
- Definitions:
  - beat = mon_tvalid & mon_tready.
  - sof = beat & mon_tuser.
  - N = FILTER_CORE_DIM**2.
- Reset (asynchronous, reset=0):
  - Shadow and active banks hold the identity kernel: all zero except the centre index (N-1)/2 = 16'h7FFF.
  - State = IDLE, timeout counter = 0.
  - cfg_busy, cfg_err, commit_done and forced_commit are all 0.
  - Reset mid-ARMED drops the pending commit; the active bank reverts to identity.
- State machine IDLE / ARMED / DONE:
  - IDLE: cfg_we with cfg_waddr < N writes the shadow bank on that edge. cfg_commit goes to ARMED. If cfg_we and cfg_commit are in the same cycle, the write lands first and is included in the commit.
  - ARMED: shadow writes are rejected. cfg_commit is ignored.
  - ARMED, on sof: active <= shadow on that same edge. forced_commit <= 0. Go to DONE.
  - ARMED, timeout: when IDLE_TIMEOUT != 0 and the counter equals IDLE_TIMEOUT-1 with no beat this cycle: active <= shadow, forced_commit <= 1, go to DONE.
  - DONE (1 cycle): commit_done = 1, writes rejected, then go to IDLE.
- Timeout counter:
  - Runs only in ARMED.
  - Increments on cycles without a beat; clears to 0 on any beat, on entry to ARMED, and outside ARMED.
  - A sof and a timeout in the same cycle count as a sof commit (forced_commit cleared).
- cfg_err pulses for one cycle, registered, in the cycle after either:
  - cfg_we with cfg_waddr >= N, in any state;
  - cfg_we while in ARMED or DONE.
  - Rejected writes never modify the shadow bank.
- Timing and registration:
  - coe_flat changes only on the commit edge and is stable for the whole frame.
  - The filter samples coe_flat no earlier than its first multiply stage, which lies at least 2 cycles after the sof beat.
  - All outputs are registered.
- The shadow bank persists after a commit. A subsequent commit with no new writes reloads identical values.

Test Plan:
- Reset → coe_flat word 12 = 16'h7FFF, all others 0; cfg_busy = 0.
- Write k=0..24 with value k+1, commit, idle 10 cycles, then sof beat → coe_flat unchanged before the sof edge; word k = k+1 after it; commit_done 1 cycle later; forced_commit = 0.
- While ARMED: write k=3 value 16'h8000 and pulse cfg_commit → cfg_err pulses; shadow[3] unchanged; only one commit_done at the next sof.
- Write k=25 in IDLE → cfg_err = 1 for one cycle; no bank change.
- IDLE_TIMEOUT=8, ARMED with no beats → active updates on the 8th idle cycle; forced_commit = 1. The next commit via sof clears it.
- Assert reset for 1 cycle while ARMED → state IDLE; coe_flat = identity; a later sof causes no update.

Source files
------------

// File: rtl/filter_coe_scheduler.sv
// filter_coe_scheduler: shadow/active coefficient banks for the stream convolution filter.
// Rev 1.0 - shadow-to-active commits on SOF, with an idle-timeout fallback.
`default_nettype none

module filter_coe_scheduler #(
  parameter int FILTER_CORE_DIM = 5,
  parameter int COE_WIDTH       = 16,
  parameter int ADDR_W          = 5,
  parameter int IDLE_TIMEOUT    = 1024
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [ADDR_W-1:0]                                    cfg_waddr,
  input  logic [COE_WIDTH-1:0]                                 cfg_wdata,
  input  logic                                                 cfg_we,
  input  logic                                                 cfg_commit,
  output logic                                                 cfg_busy,
  output logic                                                 cfg_err,
  output logic                                                 commit_done,
  output logic                                                 forced_commit,
  input  logic                                                 mon_tvalid,
  input  logic                                                 mon_tready,
  input  logic                                                 mon_tuser,
  output logic [FILTER_CORE_DIM*FILTER_CORE_DIM*COE_WIDTH-1:0] coe_flat
);

  localparam int N      = FILTER_CORE_DIM * FILTER_CORE_DIM;
  localparam int CENTRE = (N - 1) / 2;
  localparam int CNT_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]     C_TO_LAST = CNT_W'((IDLE_TIMEOUT == 0) ? 0 : IDLE_TIMEOUT - 1);
  localparam logic [ADDR_W:0]      C_N       = (ADDR_W + 1)'(N);
  localparam logic [COE_WIDTH-1:0] C_ONE     = {1'b0, {(COE_WIDTH - 1){1'b1}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [COE_WIDTH-1:0] r_shadow [N];
  logic [COE_WIDTH-1:0] r_active [N];
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_err;
  logic                 r_done;
  logic                 r_forced;

  logic w_beat, w_sof, w_addr_ok, w_wr_ok, w_wr_rej, w_timeout, w_commit;

  assign w_beat    = mon_tvalid & mon_tready;
  assign w_sof     = w_beat & mon_tuser;
  assign w_addr_ok = ({1'b0, cfg_waddr} < C_N);
  assign w_wr_ok   = cfg_we & w_addr_ok & (r_state == S_IDLE);
  assign w_wr_rej  = cfg_we & ~w_wr_ok;
  assign w_timeout = (IDLE_TIMEOUT != 0) && (r_state == S_ARMED) && !w_beat && (r_cnt == C_TO_LAST);
  // A sof arriving in the timeout cycle wins, so forced_commit stays clear.
  assign w_commit  = (r_state == S_ARMED) && (w_sof || w_timeout);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cfg_commit) w_state_nxt = S_ARMED;
      S_ARMED: if (w_commit)   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        r_shadow[k] <= (k == CENTRE) ? C_ONE : '0;
        r_active[k] <= (k == CENTRE) ? C_ONE : '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_wr_ok && (cfg_waddr == ADDR_W'(k))) r_shadow[k] <= cfg_wdata;
      end
      if (w_commit) r_active <= r_shadow;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_forced <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_err   <= w_wr_rej;
      r_done  <= w_commit;
      if ((r_state == S_ARMED) && (w_state_nxt == S_ARMED) && !w_beat) r_cnt <= r_cnt + 1'b1;
      else                                                              r_cnt <= '0;
      if (w_commit) r_forced <= ~w_sof;
    end
  end

  assign cfg_busy      = r_busy;
  assign cfg_err       = r_err;
  assign commit_done   = r_done;
  assign forced_commit = r_forced;

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign coe_flat[k*COE_WIDTH +: COE_WIDTH] = r_active[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_filter_coe_scheduler.sv
// tb_filter_coe_scheduler: directed checks on two instances (default and short idle timeout).
`default_nettype none

module tb_filter_coe_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  cfg_waddr;
  logic [15:0] cfg_wdata;
  logic        cfg_we, cfg_commit;
  logic        mon_tvalid, mon_tready, mon_tuser;

  logic         busy_a, err_a, done_a, forced_a;
  logic         busy_b, err_b, done_b, forced_b;
  logic [399:0] coe_a, coe_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_coe_scheduler #(.IDLE_TIMEOUT(1024)) u_dut_a (
    .clk(clk), .reset(reset), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_we(cfg_we), .cfg_commit(cfg_commit), .cfg_busy(busy_a), .cfg_err(err_a),
    .commit_done(done_a), .forced_commit(forced_a), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tuser(mon_tuser), .coe_flat(coe_a));

  filter_coe_scheduler #(.IDLE_TIMEOUT(8)) u_dut_b (
    .clk(clk), .reset(reset), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_we(cfg_we), .cfg_commit(cfg_commit), .cfg_busy(busy_b), .cfg_err(err_b),
    .commit_done(done_b), .forced_commit(forced_b), .mon_tvalid(mon_tvalid),
    .mon_tready(mon_tready), .mon_tuser(mon_tuser), .coe_flat(coe_b));

  function automatic logic [15:0] word(input logic [399:0] bus, input int k);
    return bus[k*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_beat();
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = 1'b1;
    step();
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_waddr = '0; cfg_wdata = '0; cfg_we = 1'b0; cfg_commit = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0;
    step(); step();

    // Reset state: identity kernel, all flags low
    for (int k = 0; k < 25; k++) chk($sformatf("rst_word%0d", k), word(coe_a, k), (k == 12) ? 16'h7FFF : 16'h0000);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_forced", forced_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    reset = 1'b1;
    step();

    // Load k+1 into every shadow slot, then arm
    for (int k = 0; k < 25; k++) begin
      cfg_we = 1'b1; cfg_waddr = 5'(k); cfg_wdata = 16'(k + 1);
      step();
    end
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("arm_busy", busy_a, 1'b1);
    chk("arm_err", err_a, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 6) chk("b_pre_timeout_w0", word(coe_b, 0), 16'h0000);
      if (i == 7) begin
        chk("b_timeout_w0", word(coe_b, 0), 16'h0001);
        chk("b_timeout_forced", forced_b, 1'b1);
        chk("b_timeout_done", done_b, 1'b1);
      end
    end
    chk("idle_w0_unchanged", word(coe_a, 0), 16'h0000);
    chk("idle_w12_unchanged", word(coe_a, 12), 16'h7FFF);
    chk("idle_busy", busy_a, 1'b1);
    chk("idle_done", done_a, 1'b0);

    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tuser = 1'b1;
    #1;
    chk("pre_sof_w0", word(coe_a, 0), 16'h0000);
    step();
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0;
    for (int k = 0; k < 25; k++) chk($sformatf("sof_word%0d", k), word(coe_a, k), 16'(k + 1));
    chk("sof_done", done_a, 1'b1);
    chk("sof_forced", forced_a, 1'b0);
    chk("sof_busy_done_state", busy_a, 1'b1);
    step();
    chk("post_done", done_a, 1'b0);
    chk("post_busy", busy_a, 1'b0);

    // Arm, then a write plus a second commit while armed
    cfg_commit = 1'b1;
    step();
    cfg_we = 1'b1; cfg_waddr = 5'd3; cfg_wdata = 16'h8000;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("armed_wr_err", err_a, 1'b1);
    step();
    chk("armed_err_pulse", err_a, 1'b0);
    chk("armed_no_done", done_a, 1'b0);
    sof_beat();
    chk("armed_w3_kept", word(coe_a, 3), 16'h0004);
    chk("armed_done", done_a, 1'b1);
    chk("b_sof_clears_forced", forced_b, 1'b0);
    chk("b_sof_done", done_b, 1'b1);
    step();
    chk("armed_single_done", done_a, 1'b0);
    chk("armed_back_idle", busy_a, 1'b0);

    // Out-of-range write in IDLE
    cfg_we = 1'b1; cfg_waddr = 5'd25; cfg_wdata = 16'hFFFF;
    step();
    cfg_we = 1'b0;
    chk("oor_err", err_a, 1'b1);
    chk("oor_busy", busy_a, 1'b0);
    step();
    chk("oor_err_pulse", err_a, 1'b0);
    chk("oor_w0", word(coe_a, 0), 16'h0001);
    chk("oor_w24", word(coe_a, 24), 16'h0019);

    // Timeout path on instance B with a fresh value
    cfg_we = 1'b1; cfg_waddr = 5'd0; cfg_wdata = 16'h1234;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 6) begin
        chk("to_b_w0_before", word(coe_b, 0), 16'h0001);
        chk("to_b_forced_before", forced_b, 1'b0);
      end
      if (i == 7) begin
        chk("to_b_w0_after", word(coe_b, 0), 16'h1234);
        chk("to_b_forced", forced_b, 1'b1);
        chk("to_b_done", done_b, 1'b1);
        chk("to_a_still_armed", busy_a, 1'b1);
        chk("to_a_w0", word(coe_a, 0), 16'h0001);
      end
    end
    sof_beat();
    chk("to_a_sof_w0", word(coe_a, 0), 16'h1234);
    chk("to_a_forced", forced_a, 1'b0);
    chk("to_a_done", done_a, 1'b1);
    chk("to_b_idle_sof_no_done", done_b, 1'b0);
    chk("to_b_forced_sticky", forced_b, 1'b1);
    step();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    sof_beat();
    chk("to_b_sof_forced_clr", forced_b, 1'b0);
    chk("to_b_sof_done", done_b, 1'b1);
    chk("to_b_sof_w0", word(coe_b, 0), 16'h1234);
    step();

    // Reset while armed drops the pending commit
    cfg_we = 1'b1; cfg_waddr = 5'd1; cfg_wdata = 16'h5555;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    step();
    chk("rst2_pre_busy", busy_a, 1'b1);
    reset = 1'b0;
    #1;
    chk("rst2_w0", word(coe_a, 0), 16'h0000);
    chk("rst2_w12", word(coe_a, 12), 16'h7FFF);
    chk("rst2_busy", busy_a, 1'b0);
    step();
    reset = 1'b1;
    sof_beat();
    chk("rst2_sof_no_done", done_a, 1'b0);
    chk("rst2_sof_busy", busy_a, 1'b0);
    chk("rst2_sof_w1", word(coe_a, 1), 16'h0000);
    chk("rst2_sof_w12", word(coe_a, 12), 16'h7FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
